// File: rtl/mem_access_if.sv
// Bundle between the MEM stage, the data cache and the load/store unit.
// Unit outputs change only from its own state and same-cycle inputs; dc_req stays high until dc_ready.
interface mem_access_if #(
  parameter int DW = 32
);
  logic          mem_read;
  logic          mem_write;
  logic [2:0]    funct3;
  logic [DW-1:0] addr;
  logic [DW-1:0] store_data;
  logic          Istall;
  logic          dc_ready;
  logic [DW-1:0] dc_rdata;
  logic          dc_req;
  logic          dc_we;
  logic [DW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic [3:0]    dc_be;
  logic [DW-1:0] Dcache_out_ext;
  logic          Dstall;
  logic          misalign;

  modport slave (
    input  mem_read, mem_write, funct3, addr, store_data, Istall, dc_ready, dc_rdata,
    output dc_req, dc_we, dc_addr, dc_wdata, dc_be, Dcache_out_ext, Dstall, misalign
  );

  modport master (
    output mem_read, mem_write, funct3, addr, store_data, Istall, dc_ready, dc_rdata,
    input  dc_req, dc_we, dc_addr, dc_wdata, dc_be, Dcache_out_ext, Dstall, misalign
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: checks size/alignment, issues one cache access per
// instruction, stalls the pipeline until dc_ready and extends load data.
module mem_access_unit #(
  parameter int DW = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_access_if.slave bus,
  output logic [1:0] state_dbg   // 0 IDLE, 1 ACCESS, 2 DONE
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] result_q, result_d;
  logic [3:0]    be_q, be_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;

  logic          is_mem, is_store, f3_legal, aligned, valid;
  logic [3:0]    be_new;
  logic [DW-1:0] wdata_new, load_ext;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  always_comb begin
    is_mem   = bus.mem_read | bus.mem_write;
    is_store = bus.mem_write;   // read+write together is treated as a store
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~is_store;
      default:                f3_legal = 1'b0;
    endcase
    case (bus.funct3[1:0])
      2'b01:   aligned = ~bus.addr[0];
      2'b10:   aligned = (bus.addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    valid = is_mem & f3_legal & aligned;

    be_new    = 4'b1111;
    wdata_new = '0;
    if (is_store) begin
      case (bus.funct3[1:0])
        2'b00: begin
          be_new    = 4'b0001 << bus.addr[1:0];
          wdata_new = {(DW/8){bus.store_data[7:0]}};
        end
        2'b01: begin
          be_new    = 4'b0011 << {bus.addr[1], 1'b0};
          wdata_new = {(DW/16){bus.store_data[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = bus.store_data;
        end
      endcase
    end
  end

  // Lane selection uses the offset captured at issue, not the live address.
  always_comb begin
    byte_sel = bus.dc_rdata[8*off_q +: 8];
    half_sel = bus.dc_rdata[16*off_q[1] +: 16];
    case (f3_q)
      3'b000:  load_ext = {{(DW-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {{(DW-8){1'b0}}, byte_sel};
      3'b001:  load_ext = {{(DW-16){half_sel[15]}}, half_sel};
      3'b101:  load_ext = {{(DW-16){1'b0}}, half_sel};
      default: load_ext = bus.dc_rdata;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    we_d               = we_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    result_d           = result_q;
    be_d               = be_q;
    f3_d               = f3_q;
    off_d              = off_q;
    bus.dc_req         = 1'b0;
    bus.dc_we          = 1'b0;
    bus.dc_addr        = addr_q;
    bus.dc_wdata       = wdata_q;
    bus.dc_be          = 4'b0000;
    bus.Dstall         = 1'b0;
    bus.misalign       = 1'b0;
    bus.Dcache_out_ext = '0;
    case (state_q)
      IDLE: begin
        bus.dc_addr  = {bus.addr[DW-1:2], 2'b00};
        bus.dc_wdata = wdata_new;
        if (valid) begin
          bus.dc_req = 1'b1;
          bus.dc_we  = is_store;
          bus.dc_be  = be_new;
          bus.Dstall = 1'b1;
          state_d    = ACCESS;
          we_d       = is_store;
          addr_d     = {bus.addr[DW-1:2], 2'b00};
          wdata_d    = wdata_new;
          be_d       = be_new;
          f3_d       = bus.funct3;
          off_d      = bus.addr[1:0];
        end else if (is_mem) begin
          bus.misalign = 1'b1;
        end
      end
      ACCESS: begin
        bus.dc_req = 1'b1;
        bus.dc_we  = we_q;
        bus.dc_be  = be_q;
        bus.Dstall = 1'b1;
        if (bus.dc_ready) begin
          result_d = we_q ? '0 : load_ext;
          state_d  = DONE;
        end
      end
      DONE: begin
        bus.Dcache_out_ext = result_q;
        // Leave only when the pipeline advances, so the instruction is not re-issued.
        if (!bus.Istall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs stay quiet for the whole reset pulse, even with a load still presented.
    if (rst) begin
      bus.dc_req         = 1'b0;
      bus.dc_we          = 1'b0;
      bus.dc_be          = 4'b0000;
      bus.Dstall         = 1'b0;
      bus.misalign       = 1'b0;
      bus.Dcache_out_ext = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      be_q     <= 4'b0000;
      f3_q     <= 3'b000;
      off_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      be_q     <= be_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
    end
  end

  assign state_dbg = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios then random accesses against a
// byte-lane reference model; inputs change at negedge, outputs are checked 1 ns later.
module tb_mem_access_unit;
  localparam int DW = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  mem_access_if #(.DW(DW)) bus();
  mem_access_unit #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int req_cnt = 0;
  int exp_req_cnt = 0;
  logic req_prev = 1'b0;
  logic [DW-1:0] exp_q[$];

  // Count cache transactions as rising edges of dc_req.
  always @(negedge clk) begin
    #3;
    if (bus.dc_req === 1'b1 && !req_prev) req_cnt++;
    req_prev = (bus.dc_req === 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_valid(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (wr) begin
      if (f3 > 3'd2) return 1'b0;
    end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      return 1'b0;
    end
    return (a % acc_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = acc_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz = acc_size(f3);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    int sz = acc_size(f3);
    int off = int'(a % 4);
    logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
    logic [31:0] v = (rdata >> (8*off)) & mask;
    if (!f3[2] && sz < 4 && (v & ((mask + 32'd1) >> 1)) != 0) v = v | ~mask;
    return v;
  endfunction

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rdata, input int lat, input int hold,
                            input string tag);
    logic [31:0] exp_res;
    logic [3:0]  exp_be;
    @(negedge clk);
    bus.mem_read = rd; bus.mem_write = wr; bus.funct3 = f3; bus.addr = a;
    bus.store_data = sd; bus.Istall = 1'b0; bus.dc_ready = 1'b0; bus.dc_rdata = $urandom;
    #1;
    if (!m_valid(rd, wr, f3, a)) begin
      check({tag, ".misalign"}, bus.misalign, rd | wr);
      check({tag, ".req"}, bus.dc_req, 0);
      check({tag, ".stall"}, bus.Dstall, 0);
      check({tag, ".out"}, bus.Dcache_out_ext, 0);
      check({tag, ".be"}, bus.dc_be, 0);
      @(negedge clk);
      bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      return;
    end
    exp_req_cnt++;
    exp_res = wr ? 32'd0 : m_load(f3, a, rdata);
    exp_be  = wr ? m_be(f3, a) : 4'hF;
    exp_q.push_back(exp_res);
    for (int i = 0; i <= lat; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      check({tag, ".req"}, bus.dc_req, 1);
      check({tag, ".stall"}, bus.Dstall, 1);
      check({tag, ".we"}, bus.dc_we, wr);
      check({tag, ".addr"}, bus.dc_addr, a & 32'hFFFF_FFFC);
      check({tag, ".be"}, bus.dc_be, exp_be);
      if (wr) check({tag, ".wdata"}, bus.dc_wdata, m_wdata(f3, sd));
      if (i == 0) check({tag, ".misalign"}, bus.misalign, 0);
    end
    @(negedge clk);
    bus.dc_ready = 1'b1; bus.dc_rdata = rdata;
    #1;
    check({tag, ".req_last"}, bus.dc_req, 1);
    check({tag, ".stall_last"}, bus.Dstall, 1);
    @(negedge clk);
    bus.dc_ready = 1'b0; bus.dc_rdata = $urandom; bus.Istall = (hold > 0);
    #1;
    check({tag, ".done_stall"}, bus.Dstall, 0);
    check({tag, ".done_req"}, bus.dc_req, 0);
    check({tag, ".done_be"}, bus.dc_be, 0);
    check({tag, ".done_we"}, bus.dc_we, 0);
    check({tag, ".result"}, bus.Dcache_out_ext, exp_q.pop_front());
    for (int j = 1; j <= hold; j++) begin
      @(negedge clk);
      bus.Istall = (j < hold);
      bus.dc_ready = 1'($urandom_range(0, 1));
      bus.dc_rdata = $urandom;
      #1;
      check({tag, ".hold_state"}, state_dbg, ST_DONE);
      check({tag, ".hold_result"}, bus.Dcache_out_ext, exp_res);
      check({tag, ".hold_req"}, bus.dc_req, 0);
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.dc_ready = 1'b0;
    @(negedge clk);
    #1;
    check({tag, ".ret_state"}, state_dbg, ST_IDLE);
    check({tag, ".ret_req"}, bus.dc_req, 0);
    check({tag, ".ret_out"}, bus.Dcache_out_ext, 0);
    check({tag, ".req_count"}, req_cnt, exp_req_cnt);
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.funct3 = 3'b000; bus.addr = '0;
    bus.store_data = '0; bus.Istall = 1'b0; bus.dc_ready = 1'b0; bus.dc_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.state", state_dbg, ST_IDLE);
    check("rst.req", bus.dc_req, 0);
    check("rst.we", bus.dc_we, 0);
    check("rst.be", bus.dc_be, 0);
    check("rst.stall", bus.Dstall, 0);
    check("rst.misalign", bus.misalign, 0);
    check("rst.out", bus.Dcache_out_ext, 0);
    rst = 1'b0;

    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, "lw");
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 0, 0, "lb");
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h8011_2233, 1, 0, "lbu");
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 0, 0, "lh_hi");
    run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF, 0, 0, "lhu_hi");
    run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 0, 0, "sh");
    run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h1234_56A5, 32'h0, 2, 0, "sb");
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, "lw_mis");
    run_access(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 0, 0, "lh_mis");
    run_access(1'b0, 1'b1, 3'b100, 32'h200, 32'h0, 32'h0, 0, 0, "sbu_illegal");
    run_access(1'b1, 1'b0, 3'b010, 32'h140, 32'h0, 32'h0BAD_F00D, 0, 3, "hold");
    run_access(1'b1, 1'b1, 3'b010, 32'h300, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, "rdwr");
    run_access(1'b0, 1'b0, 3'b010, 32'h301, 32'h0, 32'h0, 0, 0, "nomem");

    // Reset pulse while a load waits in ACCESS; a late dc_ready must be ignored.
    @(negedge clk);
    bus.mem_read = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h400;
    #1;
    check("rstmid.req_issue", bus.dc_req, 1);
    exp_req_cnt++;
    @(negedge clk);
    rst = 1'b1; bus.mem_read = 1'b0;
    #1;
    check("rstmid.state", state_dbg, ST_IDLE);
    check("rstmid.req", bus.dc_req, 0);
    check("rstmid.stall", bus.Dstall, 0);
    @(negedge clk);
    rst = 1'b0; bus.dc_ready = 1'b1; bus.dc_rdata = 32'hCAFE_F00D;
    #1;
    check("rstmid.req_after", bus.dc_req, 0);
    @(negedge clk);
    bus.dc_ready = 1'b0;
    #1;
    check("rstmid.state_after", state_dbg, ST_IDLE);
    check("rstmid.out", bus.Dcache_out_ext, 0);
    check("rstmid.req_count", req_cnt, exp_req_cnt);

    for (int k = 0; k < 60; k++) begin
      logic [31:0] ra;
      ra = $urandom;
      run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), ra, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 2), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
